// File: rtl/piso_pkg.sv
// Shared definitions for the frame scheduler feeding the LSB-first byte shifter.
package piso_pkg;

   localparam int NREQ_DEFAULT   = 2;
   localparam int MAXLEN_DEFAULT = 16;
   localparam int GAP_DEFAULT    = 2;
   localparam int BYTE_W         = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_SHIFT,
      S_GAP
   } state_e;

endpackage

// File: rtl/piso_tx_sched_if.sv
// Requester byte streams plus the scheduler's shifter-side outputs.
// master = requester/sink side, slave = scheduler.
interface piso_tx_sched_if #(
   parameter int NREQ = piso_pkg::NREQ_DEFAULT
) ();
   import piso_pkg::*;

   logic [NREQ-1:0]        req_valid;
   logic [NREQ*BYTE_W-1:0] req_data;
   logic [NREQ-1:0]        req_last;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0]        grant;
   logic                   load;
   logic [BYTE_W-1:0]      pi;
   logic                   crc_en;
   logic                   busy;
   logic                   err;

   modport master (
      output req_valid, req_data, req_last,
      input  req_ready, grant, load, pi, crc_en, busy, err
   );

   modport slave (
      input  req_valid, req_data, req_last,
      output req_ready, grant, load, pi, crc_en, busy, err
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin search: first requester at or after ptr (wrapping) wins.
module rr_arbiter #(
   parameter  int N  = 2,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   logic          found;
   logic [PW-1:0] idx;

   // Scan requesters starting at ptr and grant the first one found.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/piso_tx_sched.sv
// Frame scheduler: picks a requester round-robin, streams its bytes into an
// 8-bit LSB-first shifter back-to-back, then idles GAP cycles between frames.
module piso_tx_sched
   import piso_pkg::*;
#(
   parameter int NREQ   = NREQ_DEFAULT,
   parameter int MAXLEN = MAXLEN_DEFAULT,
   parameter int GAP    = GAP_DEFAULT
) (
   input logic             clk,
   input logic             rst,
   piso_tx_sched_if.slave  bus
);

   localparam int PW      = $clog2(NREQ);
   localparam int CNT_MAX = (MAXLEN > GAP) ? MAXLEN : GAP;
   localparam int CW      = $clog2(CNT_MAX + 1);

   state_e            state_q, state_d;
   logic [2:0]        bc_q, bc_d;
   // nb counts bytes in SHIFT and is reused as the idle-cycle counter in GAP.
   logic [CW-1:0]     nb_q, nb_d;
   logic              last_q, last_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic              err_q, err_d;

   logic [NREQ-1:0]   arb_gnt;
   logic [PW-1:0]     owner_idx;
   logic [PW-1:0]     next_ptr;
   logic [BYTE_W-1:0] owner_data;
   logic              owner_valid;
   logic              owner_last;
   logic              ld;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req (bus.req_valid),
      .ptr (ptr_q),
      .gnt (arb_gnt)
   );

   // Select the frame owner's byte, flags and index from the one-hot grant.
   always_comb begin
      owner_idx  = '0;
      owner_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_q[i]) begin
            owner_idx  = PW'(i);
            owner_data = bus.req_data[i*BYTE_W +: BYTE_W];
         end
      end
      owner_valid = |(bus.req_valid & grant_q);
      owner_last  = |(bus.req_last & grant_q);
      next_ptr    = (owner_idx == PW'(NREQ - 1)) ? '0 : owner_idx + PW'(1);
   end

   // Next-state logic and the combinational load strobe.
   always_comb begin
      state_d = state_q;
      bc_d    = bc_q;
      nb_d    = nb_q;
      last_d  = last_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      err_d   = 1'b0;
      ld      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (|bus.req_valid) begin
               grant_d = arb_gnt;
               state_d = S_START;
            end
         end
         S_START: begin
            ld      = 1'b1;
            bc_d    = 3'd0;
            nb_d    = CW'(1);
            last_d  = owner_last;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            bc_d = bc_q + 3'd1;
            if (bc_q == 3'd7) begin
               if (!last_q && nb_q != CW'(MAXLEN) && owner_valid) begin
                  ld     = 1'b1;
                  nb_d   = nb_q + CW'(1);
                  last_d = owner_last;
               end else begin
                  // Ending the frame: overlength or underrun also pulse err.
                  err_d   = !last_q;
                  state_d = S_GAP;
                  grant_d = '0;
                  nb_d    = '0;
                  // ptr is only consulted in IDLE, so advancing it here is
                  // equivalent to advancing it on the way out of GAP.
                  ptr_d   = next_ptr;
               end
            end
         end
         S_GAP: begin
            nb_d = nb_q + CW'(1);
            if (nb_q == CW'(GAP - 1)) begin
               nb_d    = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         bc_q    <= '0;
         nb_q    <= '0;
         last_q  <= 1'b0;
         grant_q <= '0;
         ptr_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state_q <= state_d;
         bc_q    <= bc_d;
         nb_q    <= nb_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
      end
   end

   assign bus.load      = ld;
   assign bus.req_ready = ld ? grant_q : '0;
   assign bus.grant     = grant_q;
   assign bus.pi        = owner_data;
   assign bus.crc_en    = (state_q == S_SHIFT) && (nb_q >= CW'(2));
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.err       = err_q;

endmodule

// File: tb/tb_piso_tx_sched.sv
// Self-checking bench: queue-based requesters, frame-level reference model,
// serial reconstruction through a behavioural 8-bit LSB-first shifter.
module tb_piso_tx_sched;
   import piso_pkg::*;

   localparam int NREQ   = 2;
   localparam int MAXLEN = 4;
   localparam int GAP    = 2;

   typedef struct packed {
      logic              last;
      logic [BYTE_W-1:0] data;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   piso_tx_sched_if #(.NREQ(NREQ)) bus ();

   piso_tx_sched #(.NREQ(NREQ), .MAXLEN(MAXLEN), .GAP(GAP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Requester queues (one beat per byte) and monitor/model state.
   beat_t             rq [NREQ][$];
   logic [NREQ-1:0]   pend = '0;
   logic [NREQ-1:0]   drv_valid = '0;
   logic [NREQ-1:0]   prev_valid = '0;
   logic [BYTE_W-1:0] sh = '0;
   bit                mon_in_frame = 1'b0;
   int                mon_k = 0;
   int                frames_done = 0;
   int                mptr = 0;
   int                exp_owner, exp_n, exp_err;
   logic [BYTE_W-1:0] exp_bytes [MAXLEN];
   logic [BYTE_W-1:0] rx [MAXLEN];
   int                cnt_ready, cnt_foreign, load_bad, crc_cnt, err_cnt, err_k, gap_grant_bad;
   int                stray = 0;
   int                owner_hist [$];

   task automatic push_beat(input int r, input logic [BYTE_W-1:0] d, input logic l);
      beat_t b;
      b.data = d;
      b.last = l;
      rq[r].push_back(b);
   endtask

   task automatic drive_inputs();
      logic [NREQ-1:0]        v;
      logic [NREQ-1:0]        l;
      logic [NREQ*BYTE_W-1:0] d;
      v = '0;
      l = '0;
      d = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (rq[i].size() > 0) begin
            v[i] = 1'b1;
            l[i] = rq[i][0].last;
            d[i*BYTE_W +: BYTE_W] = rq[i][0].data;
         end
      end
      bus.req_valid = v;
      bus.req_last  = l;
      bus.req_data  = d;
      drv_valid     = v;
   endtask

   // Frame-level model: decide owner and the whole frame from queue contents.
   task automatic start_frame();
      int  own;
      bit  done;
      own  = -1;
      for (int j = 0; j < NREQ; j++) begin
         int c;
         c = (mptr + j) % NREQ;
         if (own < 0 && prev_valid[c]) own = c;
      end
      if (own < 0) begin
         check("arb_without_request", 32'(bus.grant), 0);
         own = 0;
      end
      exp_owner = own;
      exp_n     = 0;
      exp_err   = 0;
      done      = 1'b0;
      for (int idx = 0; idx < rq[own].size() && !done; idx++) begin
         exp_bytes[exp_n] = rq[own][idx].data;
         exp_n++;
         if (rq[own][idx].last) done = 1'b1;
         else if (exp_n == MAXLEN || idx == rq[own].size() - 1) begin
            exp_err = 1;
            done    = 1'b1;
         end
      end
      if (exp_n == 0) begin
         exp_n   = 1;
         exp_err = 1;
      end
      mptr = (own + 1) % NREQ;
      owner_hist.push_back(own);
      check("grant_owner", 32'(bus.grant), 32'(1) << own);
      mon_k = 0;
      cnt_ready = 0; cnt_foreign = 0; load_bad = 0; crc_cnt = 0;
      err_cnt = 0; err_k = -1; gap_grant_bad = 0;
      for (int j = 0; j < MAXLEN; j++) rx[j] = '0;
      mon_in_frame = 1'b1;
   endtask

   task automatic end_frame();
      check("ready_pulses", cnt_ready, exp_n);
      check("foreign_ready", cnt_foreign, 0);
      check("load_timing", load_bad, 0);
      for (int j = 0; j < exp_n; j++) check("serial_byte", 32'(rx[j]), 32'(exp_bytes[j]));
      check("crc_bits", crc_cnt, 8 * (exp_n - 1));
      check("err_pulses", err_cnt, exp_err);
      if (exp_err != 0) check("err_cycle", err_k, 8 * exp_n + 1);
      check("gap_grant_clear", gap_grant_bad, 0);
      check("frame_cycles", mon_k, 1 + 8 * exp_n + GAP);
      mon_in_frame = 1'b0;
      frames_done++;
   endtask

   task automatic monitor_step();
      logic exp_load;
      logic [NREQ-1:0] own_mask;
      if (!rst) begin
         mon_in_frame = 1'b0;
         sh   = '0;
         mptr = 0;
         return;
      end
      if (!mon_in_frame && bus.busy) start_frame();
      if (mon_in_frame) begin
         if (mon_k > 0 && !bus.busy) begin
            end_frame();
         end else begin
            own_mask = NREQ'(1) << exp_owner;
            exp_load = (mon_k % 8 == 0) && (mon_k / 8 < exp_n);
            if (bus.load !== exp_load) load_bad++;
            if (bus.req_ready[exp_owner]) cnt_ready++;
            if ((bus.req_ready & ~own_mask) != '0) cnt_foreign++;
            if (bus.crc_en) crc_cnt++;
            if (bus.err) begin
               err_cnt++;
               err_k = mon_k;
            end
            if (mon_k == 8 * exp_n + 1 && bus.grant != '0) gap_grant_bad++;
            if (mon_k >= 1 && mon_k <= 8 * exp_n) rx[(mon_k-1)/8][(mon_k-1)%8] = sh[0];
            mon_k++;
            if (mon_k > 1 + 8 * MAXLEN + GAP + 4) begin
               check("frame_timeout", mon_k, 1 + 8 * exp_n + GAP);
               mon_in_frame = 1'b0;
            end
         end
      end else if (bus.req_ready != '0 || bus.err || bus.load) begin
         stray++;
      end
      sh = bus.load ? bus.pi : {1'b0, sh[BYTE_W-1:1]};
   endtask

   // Requester driver and monitor: inputs change on negedge, outputs sampled 1 later.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++)
            if (pend[i] && rq[i].size() > 0) void'(rq[i].pop_front());
         pend = '0;
         drive_inputs();
         #1;
         monitor_step();
         if (rst) pend = bus.req_ready;
         prev_valid = drv_valid;
      end
   end

   task automatic wait_drain();
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 4000 && !ok; c++) begin
         @(negedge clk);
         #2;
         if (rq[0].size() == 0 && rq[1].size() == 0 && !mon_in_frame && !bus.busy) ok = 1'b1;
      end
      check("drain", 32'(ok), 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},   32'(bus.busy), 0);
      check({tag, "_load"},   32'(bus.load), 0);
      check({tag, "_grant"},  32'(bus.grant), 0);
      check({tag, "_ready"},  32'(bus.req_ready), 0);
      check({tag, "_pi"},     32'(bus.pi), 0);
      check({tag, "_crc_en"}, 32'(bus.crc_en), 0);
      check({tag, "_err"},    32'(bus.err), 0);
   endtask

   task automatic reset_pulse();
      @(negedge clk); #2; rst = 1'b0;
      for (int i = 0; i < NREQ; i++) rq[i].delete();
      @(negedge clk); #2; rst = 1'b1;
   endtask

   initial begin
      int  base;
      int  fd0;
      bit  hit;

      #2;
      check_all_zero("reset");
      @(negedge clk); #2; rst = 1'b1;

      // Three-byte frame from req0.
      push_beat(0, 8'hA5, 1'b0);
      push_beat(0, 8'h3C, 1'b0);
      push_beat(0, 8'h81, 1'b1);
      wait_drain();

      // Simultaneous requests after reset: req0, then req1, then req0 again.
      reset_pulse();
      base = owner_hist.size();
      push_beat(0, 8'h01, 1'b0); push_beat(0, 8'h02, 1'b1);
      push_beat(1, 8'h11, 1'b0); push_beat(1, 8'h12, 1'b1);
      wait_drain();
      push_beat(0, 8'h03, 1'b1);
      push_beat(1, 8'h13, 1'b1);
      wait_drain();
      check("rr_first",  owner_hist[base],     0);
      check("rr_second", owner_hist[base + 1], 1);
      check("rr_third",  owner_hist[base + 2], 0);

      // Underrun: req0 offers a header but no second byte.
      push_beat(0, 8'h5A, 1'b0);
      wait_drain();

      // Overlength: six bytes, never last; the fifth stays pending.
      fd0 = frames_done;
      for (int b = 0; b < 6; b++) push_beat(0, 8'(8'h11 + b), 1'b0);
      hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
         @(negedge clk); #2;
         if (frames_done > fd0) hit = 1'b1;
      end
      check("ovl_frame_seen", 32'(hit), 1);
      check("ovl_pending_cnt", rq[0].size(), 2);
      if (rq[0].size() > 0) check("ovl_pending_byte", 32'(rq[0][0].data), 32'h15);
      wait_drain();

      // Reset at bit 3 of byte 2, then a clean frame from req1.
      push_beat(0, 8'hC1, 1'b0); push_beat(0, 8'hC2, 1'b0); push_beat(0, 8'hC3, 1'b1);
      hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
         @(negedge clk); #2;
         if (mon_in_frame && mon_k == 13) hit = 1'b1;
      end
      check("rst_point_reached", 32'(hit), 1);
      rst = 1'b0;
      #1;
      check_all_zero("midrst");
      for (int i = 0; i < NREQ; i++) rq[i].delete();
      @(negedge clk); #2; rst = 1'b1;
      push_beat(1, 8'hD1, 1'b0); push_beat(1, 8'hD2, 1'b1);
      wait_drain();
      check("post_rst_owner", owner_hist[owner_hist.size() - 1], 1);

      // Randomized rounds: mixed lengths, overlength and truncated frames.
      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 9) < 7) begin
               int nf;
               nf = $urandom_range(1, 2);
               for (int f = 0; f < nf; f++) begin
                  int len;
                  bit trunc;
                  len   = $urandom_range(1, 6);
                  trunc = ($urandom_range(0, 5) == 0);
                  for (int b = 0; b < len; b++)
                     push_beat(i, 8'($urandom), (b == len - 1) && !trunc);
               end
            end
         end
         wait_drain();
      end

      check("stray_outputs", stray, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/piso_tx_sched.md
PISO_TX_SCHED -- requirements
Module: piso_tx_sched

Interface
REQ-001 Parameter NREQ, default 2, number of byte-stream requesters (2..8).
REQ-002 Parameter MAXLEN, default 16, maximum bytes per frame, header included.
REQ-003 Parameter GAP, default 2, idle clock cycles inserted between frames (>=1).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  NREQ  per-requester byte available.
REQ-007 req_data  input  8*NREQ  per-requester byte; slice i belongs to requester i.
REQ-008 req_last  input  NREQ  per-requester "this byte ends the frame".
REQ-009 req_ready  output  NREQ  per-requester byte-accepted strobe.
REQ-010 grant  output  NREQ  one-hot frame owner; all-zero when no frame is in progress.
REQ-011 load  output  1  parallel-load strobe to the downstream 8-bit LSB-first shifter.
REQ-012 pi  output  8  byte presented to the shifter.
REQ-013 crc_en  output  1  CRC accumulate enable, one cycle per serial bit.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 err  output  1  one-cycle abort pulse.

Function
REQ-016 States: IDLE, START, SHIFT, GAP; the state register, a 3-bit bit counter bc, a byte counter nb and a last flag are the only datapath state.
REQ-017 IDLE: when any req_valid is high at a clock edge, a round-robin winner is latched into grant and the FSM enters START; otherwise it stays in IDLE.
REQ-018 Round-robin: the search starts at pointer ptr (0 after reset); on leaving GAP, ptr becomes (owner+1) mod NREQ.
REQ-019 START lasts exactly one cycle: load=1, bc<=0, nb<=1, last<=req_last[owner], next state SHIFT.
REQ-020 The grant owner's req_valid is guaranteed high in START, as the requester holds valid until ready.
REQ-021 load is combinational: high in START, or in SHIFT when bc==7, last==0, nb<MAXLEN and req_valid[owner]==1.
REQ-022 req_ready[i] = load AND grant[i]; no other requester ever sees ready.
REQ-023 pi = req_data slice of the grant owner; pi = 0 when grant is zero.
REQ-024 SHIFT: bc increments every cycle, wrapping from 7 to 0; each SHIFT cycle is one serial bit-time.
REQ-025 A load in SHIFT (bc==7) sets nb<=nb+1 and last<=req_last[owner]; the next byte follows back-to-back with no idle bit.
REQ-026 crc_en = (state==SHIFT) AND (nb>=2); the header byte is never CRC-covered.
REQ-027 Normal end: SHIFT with bc==7 and last==1 -> GAP, with no load and no err.
REQ-028 Underrun: SHIFT with bc==7, last==0 and req_valid[owner]==0 -> err=1 for that cycle, then GAP.
REQ-029 Overlength: SHIFT with bc==7, last==0 and nb==MAXLEN -> err=1, no load, then GAP; the requester's pending byte is not consumed.
REQ-030 GAP: grant is cleared on entry; the state lasts exactly GAP cycles and then returns to IDLE.
REQ-031 err is registered: it is driven on the edge that enters GAP and is visible for the first GAP cycle.
REQ-032 Latency: a byte accepted in START appears on the serial output 1 cycle later; a frame of N bytes occupies 1 + 8N + GAP cycles from START to IDLE.

Reset
REQ-033 rst low asynchronously forces IDLE, ptr=0, bc=0, nb=0, last=0, grant=0 and err=0, which gives load=0, req_ready=0, pi=0, crc_en=0 and busy=0.
REQ-034 Reset mid-frame drops the frame silently: no err pulse and no ready pulse; after release, arbitration restarts at requester 0.

Structure
REQ-035 Shared package piso_pkg holds the state enum, the default values of NREQ, MAXLEN and GAP, and the BYTE_W=8 constant.
REQ-036 The round-robin search is one sub-module, rr_arbiter (inputs req and ptr; output one-hot gnt); everything else stays in piso_tx_sched.

Verification
REQ-037 Single requester, NREQ=2: req0 sends 3 bytes A5,3C,81 (last on 81) -> load at cycles 0, 8 and 16; crc_en high for exactly 16 cycles; busy low again after 1+24+2 cycles.
REQ-038 Both requesters valid from IDLE after reset -> req0 is served first and req1 next; a further simultaneous request after that goes to req0 again.
REQ-039 req0 drops valid before its second byte -> err is pulsed once at the entry to GAP; only 1 ready pulse; grant clears.
REQ-040 MAXLEN=4 with req0 never asserting last -> 4 ready pulses, err=1, and the 5th byte is still pending on req0.
REQ-041 rst asserted at bit 3 of byte 2 -> all outputs are 0 immediately; after release, a fresh frame from req1 completes without err.
REQ-042 Bench model: an 8-bit shifter (load takes pi, otherwise shift right by 1) -> the serial bit stream matches the sent bytes LSB-first, and the CRC bit count equals 8*(N-1).
